// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared geometry, opcode and address helpers for the LED framebuffer
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int COLUMNS = 64;
  localparam int ROWS    = 64;
  localparam int COLOR_W = 4;
  localparam int X_W     = $clog2(COLUMNS);
  localparam int Y_W     = $clog2(ROWS);
  localparam int ADDR_W  = X_W + Y_W;

  typedef enum logic [1:0] {
    PIXEL = 2'd0,
    RECT  = 2'd1,
    CLEAR = 2'd2
  } fb_op_t;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [Y_W-1:0] y,
                                                input logic [X_W-1:0] x);
    return {y, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rect_scan.sv
`default_nettype none
// ============================================================================
// Module   : fb_rect_scan
// Brief    : Row-major x/y scanner over a loaded rectangle, with last flag
// Revision : 1.0 - initial release
// ============================================================================
module fb_rect_scan
  import fb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] xa,
  input  logic [X_W-1:0] xb,
  input  logic [Y_W-1:0] ya,
  input  logic [Y_W-1:0] yb,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] r_x, r_xa, r_xb;
  logic [Y_W-1:0] r_y, r_yb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_xa <= '0;
      r_xb <= '0;
      r_yb <= '0;
    end else if (load) begin
      r_x  <= xa;
      r_y  <= ya;
      r_xa <= xa;
      r_xb <= xb;
      r_yb <= yb;
    end else if (step && !last) begin
      // Guarded on both axes so a full-screen scan stops at the far corner.
      if (r_x == r_xb) begin
        r_x <= r_xa;
        if (r_y != r_yb) r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = (r_x == r_xb) && (r_y == r_yb);

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_writer
// Brief    : Command-driven pixel/rect/clear write port for the LED framebuffer
// Revision : 1.0 - initial release
// ============================================================================
module fb_writer
  import fb_pkg::*;
#(
  parameter int COLUMNS = fb_pkg::COLUMNS,
  parameter int ROWS    = fb_pkg::ROWS,
  parameter int COLOR_W = fb_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [ADDR_W-1:0]  waddr,
  output logic [COLOR_W-1:0] din,
  output logic               we,
  output logic               busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [X_W-1:0] c_X_MAX = X_W'(COLUMNS - 1);
  localparam logic [Y_W-1:0] c_Y_MAX = Y_W'(ROWS - 1);

  state_t               r_state, w_next;
  logic                 r_we, w_we;
  logic [COLOR_W-1:0]   r_din;
  logic                 w_accept, w_load, w_step, w_last;
  logic [X_W-1:0]       w_ld_xa, w_ld_xb, w_scan_x;
  logic [Y_W-1:0]       w_ld_ya, w_ld_yb, w_scan_y;

  assign cmd_ready = (r_state == IDLE) || w_last;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_ld_xa = cmd_x0;
    w_ld_xb = cmd_x0;
    w_ld_ya = cmd_y0;
    w_ld_yb = cmd_y0;
    if (r_state == FILL && !w_last) begin
      w_step = 1'b1;
      w_we   = 1'b1;
    end else begin
      w_next = IDLE;
      if (w_accept) begin
        case (cmd_op)
          PIXEL: begin
            w_load = 1'b1;
            w_we   = 1'b1;
          end
          RECT: begin
            w_load  = 1'b1;
            w_we    = 1'b1;
            w_next  = FILL;
            w_ld_xa = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
            w_ld_xb = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
            w_ld_ya = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
            w_ld_yb = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
          end
          CLEAR: begin
            w_load  = 1'b1;
            w_we    = 1'b1;
            w_next  = FILL;
            w_ld_xa = '0;
            w_ld_xb = c_X_MAX;
            w_ld_ya = '0;
            w_ld_yb = c_Y_MAX;
          end
          default: ; // reserved opcode: handshake only
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= w_we;
      if (w_load) r_din <= cmd_color;
    end
  end

  // The scanner position is the address currently being written.
  fb_rect_scan u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .step  (w_step),
    .xa    (w_ld_xa),
    .xb    (w_ld_xb),
    .ya    (w_ld_ya),
    .yb    (w_ld_yb),
    .x     (w_scan_x),
    .y     (w_scan_y),
    .last  (w_last)
  );

  assign waddr = fb_addr(w_scan_y, w_scan_x);
  assign din   = r_din;
  assign we    = r_we;
  assign busy  = (r_state == FILL);

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_writer
// Brief    : Directed self-checking bench for fb_writer
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [3:0]  cmd_color = '0;
  logic [11:0] waddr;
  logic [3:0]  din;
  logic        we;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fb_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .waddr     (waddr),
    .din       (din),
    .we        (we),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [5:0] x0, input logic [5:0] y0,
                         input logic [5:0] x1, input logic [5:0] y1, input logic [3:0] col);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_color = col;
  endtask

  logic [11:0] rect_exp [6];
  logic [5:0]  px [8];
  logic [5:0]  py [8];
  logic [11:0] pa [8];

  initial begin
    int errs;
    int ready_errs;
    rect_exp = '{12'h041, 12'h042, 12'h043, 12'h081, 12'h082, 12'h083};
    px = '{6'd0, 6'd9, 6'd18, 6'd27, 6'd36, 6'd45, 6'd54, 6'd63};
    py = '{6'd3, 6'd10, 6'd17, 6'd24, 6'd31, 6'd38, 6'd45, 6'd52};
    pa = '{12'h0C0, 12'h289, 12'h452, 12'h61B, 12'h7E4, 12'h9AD, 12'hB76, 12'hD3F};

    // Reset
    repeat (3) tick();
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_we_after", we, 0);

    // Single PIXEL
    set_cmd(2'd0, 6'd5, 6'd40, 6'd0, 6'd0, 4'hA);
    tick();
    cmd_valid = 1'b0;
    check("pix_we", we, 1);
    check("pix_waddr", waddr, 12'hA05);
    check("pix_din", din, 4'hA);
    check("pix_busy", busy, 0);
    tick();
    check("pix_we_off", we, 0);
    check("pix_waddr_hold", waddr, 12'hA05);

    // RECT with swapped corners
    set_cmd(2'd1, 6'd3, 6'd2, 6'd1, 6'd1, 4'h7);
    tick();
    cmd_valid = 1'b0;
    errs = 0;
    ready_errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (we !== 1'b1 || waddr !== rect_exp[i] || din !== 4'h7 || busy !== 1'b1) errs++;
      if (cmd_ready !== (i == 5)) ready_errs++;
      if (i < 5) tick();
    end
    check("rect_writes", errs, 0);
    check("rect_ready", ready_errs, 0);
    check("rect_last_addr", waddr, 12'h083);
    tick();
    check("rect_done_we", we, 0);
    check("rect_done_busy", busy, 0);

    // CLEAR then back-to-back PIXEL held while not ready
    set_cmd(2'd2, 6'd7, 6'd7, 6'd9, 6'd9, 4'h0);
    tick();
    set_cmd(2'd0, 6'd0, 6'd0, 6'd0, 6'd0, 4'hF);
    errs = 0;
    ready_errs = 0;
    for (int i = 0; i < 4096; i++) begin
      if (we !== 1'b1 || waddr !== 12'(i) || din !== 4'h0 || busy !== 1'b1) errs++;
      if (cmd_ready !== (i == 4095)) ready_errs++;
      if (i < 4095) tick();
    end
    check("clr_writes", errs, 0);
    check("clr_ready", ready_errs, 0);
    tick();
    cmd_valid = 1'b0;
    check("clr_pix_we", we, 1);
    check("clr_pix_waddr", waddr, 12'h000);
    check("clr_pix_din", din, 4'hF);
    check("clr_pix_busy", busy, 0);
    tick();
    check("clr_pix_we_off", we, 0);

    // Eight streamed PIXELs
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      set_cmd(2'd0, px[k], py[k], 6'd0, 6'd0, 4'(k + 1));
      tick();
      if (we !== 1'b1 || waddr !== pa[k] || din !== 4'(k + 1)) errs++;
    end
    cmd_valid = 1'b0;
    check("stream_writes", errs, 0);
    tick();
    check("stream_we_off", we, 0);

    // Reserved opcode: consumed, no write
    set_cmd(2'd3, 6'd1, 6'd1, 6'd2, 6'd2, 4'h5);
    tick();
    cmd_valid = 1'b0;
    check("rsv_we", we, 0);
    check("rsv_busy", busy, 0);
    check("rsv_waddr_hold", waddr, 12'hD3F);
    check("rsv_din_hold", din, 4'h8);

    // Degenerate RECT
    set_cmd(2'd1, 6'd10, 6'd20, 6'd10, 6'd20, 4'h3);
    tick();
    cmd_valid = 1'b0;
    check("deg_we", we, 1);
    check("deg_waddr", waddr, 12'h50A);
    check("deg_busy", busy, 1);
    check("deg_ready", cmd_ready, 1);
    tick();
    check("deg_we_off", we, 0);
    check("deg_busy_off", busy, 0);

    // Reset asserted during write 10 of a CLEAR
    set_cmd(2'd2, 6'd0, 6'd0, 6'd0, 6'd0, 4'h6);
    tick();
    cmd_valid = 1'b0;
    repeat (9) tick();
    check("mid_waddr_w10", waddr, 12'h009);
    check("mid_we_w10", we, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_we", we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_waddr", waddr, 0);
    tick();
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (we !== 1'b0 || busy !== 1'b0) errs++;
    end
    check("post_rst_idle", errs, 0);
    check("post_rst_ready", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
